stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//   Parametrised N-way, WIDTH-bit streaming multiplexer. Successor to the fixed 4-way 16-bit mux.
//   Adds valid/ready handshakes, a registered output stage and two selection modes:
//   explicit SEL, or round-robin across requesting channels.
//   Merges several producers (CPU/IO/DMA data paths) onto one consumer bus.
// PARAMETERS
//   WIDTH   16   data bits per channel
//   N       4    number of input channels, 2..16
//   SELW    (localparam) $clog2(N); width of SEL and OUT_CH
// PORTS
//   CLK        in   1        single clock; everything on posedge
//   RESET      in   1        synchronous, active-high
//   IN_DATA    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   IN_VALID   in   N        per-channel valid
//   IN_READY   out  N        per-channel ready; at most one bit high
//   MODE       in   1        0 = explicit SEL, 1 = round-robin
//   SEL        in   SELW     channel select when MODE=0
//   OUT_DATA   out  WIDTH    registered output data
//   OUT_VALID  out  1        output holds a beat
//   OUT_READY  in   1        consumer accepts the beat
//   OUT_CH     out  SELW     source channel of the current OUT_DATA
// BEHAVIOUR
//   - Reset (RESET high at posedge):
//     - OUT_VALID=0, OUT_DATA=0, OUT_CH=0.
//     - RR pointer last=N-1, so channel 0 has top priority first.
//     - Any held beat is dropped.
//     - IN_READY=0 while RESET is high.
//   - Output stage: 1-entry register; load = !OUT_VALID | OUT_READY.
//     - Full throughput: 1 beat/cycle under continuous OUT_READY.
//     - Latency: input handshake at cycle t -> OUT_VALID with that data at t+1.
//   - Grant (combinational, every cycle):
//     - MODE=0: g=SEL if SEL<N and IN_VALID[SEL], else none. SEL>=N never grants.
//     - MODE=1: first i with IN_VALID[i], scanning last+1, last+2, ... modulo N (wraps N-1 -> 0).
//   - IN_READY[g] = load & grant_valid; all other bits 0. Ready must not depend on the channel's own valid beyond grant.
//   - Transfer on channel g:
//     - OUT_DATA <= IN_DATA[g]; OUT_CH <= g; OUT_VALID <= 1; last <= g.
//     - last updates only on a transfer, never on stall.
//   - No grant and load: OUT_VALID <= 0; OUT_DATA and OUT_CH hold their old values.
//   - OUT_VALID & !OUT_READY: OUT_DATA, OUT_CH, OUT_VALID are stable; all IN_READY=0.
//   - MODE/SEL changes affect the next arbitration only and never alter a held beat. The RR pointer is kept across MODE switches.
//   - Single requester in RR: it is granted every cycle (back-to-back).
// CONFIGURATION
//   STREAM_MUX_LOCK_EN defined:
//     - Adds IN_LAST (in, N) and OUT_LAST (out, 1, registered with data, reset 0).
//     - After a transfer with IN_LAST[g]=0, grant is locked to g: ignore SEL/MODE/other valids until a beat with IN_LAST[g]=1 transfers.
//     - While locked and !IN_VALID[g], no grant.
//     - RESET clears the lock.
//   STREAM_MUX_LOCK_EN undefined:
//     - No LAST ports.
//     - Arbitration is independent every beat.
// TESTING
//   1. Reset, N=4: OUT_VALID=0, OUT_DATA=0, IN_READY=4'b0000. First RR grant with IN_VALID=4'b1111 is ch0.
//   2. MODE=0, SEL=2, IN_DATA ch2=16'hBEEF, OUT_READY=1: OUT_DATA=16'hBEEF, OUT_CH=2 one cycle later. SEL=2 with IN_VALID[2]=0 -> no IN_READY.
//   3. MODE=1, IN_VALID=4'b1111, OUT_READY=1 for 6 cycles -> OUT_CH sequence 0,1,2,3,0,1 (wrap).
//   4. OUT_READY=0 for 3 cycles with beat 16'h1234 held: OUT_DATA stable, IN_READY=0. Release -> 1234 consumed, next beat follows at once.
//   5. N=3, MODE=0, SEL=3: no grant ever. RESET mid-stall: OUT_VALID=0 on the next cycle, pointer back to N-1.
//   6. LOCK_EN, MODE=1: ch1 sends 3 beats with LAST on the 3rd while ch0/ch2 are valid -> OUT_CH=1,1,1 then 2.

Source files
------------

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_rr
//  Description : Parametrised N-way, WIDTH-bit streaming multiplexer with
//                valid/ready handshakes, a registered 1-entry output stage
//                and two selection modes (explicit SEL or round-robin).
//                Optional macro STREAM_MUX_LOCK_EN adds packet locking via
//                IN_LAST / OUT_LAST.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N*WIDTH-1:0] IN_DATA,
    input  logic [N-1:0]       IN_VALID,
    output logic [N-1:0]       IN_READY,
    input  logic               MODE,
    input  logic [SELW-1:0]    SEL,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [SELW-1:0]    OUT_CH
`ifdef STREAM_MUX_LOCK_EN
    ,
    input  logic [N-1:0]       IN_LAST,
    output logic               OUT_LAST
`endif
);

    // Channel index base+k, wrapping modulo N.
    function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N;
        return SELW'(s);
    endfunction

    logic [WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [SELW-1:0]  r_out_ch_q,    w_out_ch_d;
    logic [SELW-1:0]  r_last_q,      w_last_d;

    logic             w_load;
    logic             w_rr_valid;
    logic [SELW-1:0]  w_rr_ch;
    logic             w_grant_valid;
    logic [SELW-1:0]  w_grant_ch;
    logic             w_xfer;
    logic [N-1:0]     w_ready;

`ifdef STREAM_MUX_LOCK_EN
    logic             r_out_last_q, w_out_last_d;
    logic             r_lock_q,     w_lock_d;
    logic [SELW-1:0]  r_lock_ch_q,  w_lock_ch_d;
`endif

    // The output register may take a new beat when empty or being drained.
    assign w_load = !r_out_valid_q | OUT_READY;

    // Round-robin search: first valid channel after the last granted one.
    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_ch    = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_rr_valid && IN_VALID[rr_idx(r_last_q, k)]) begin
                w_rr_valid = 1'b1;
                w_rr_ch    = rr_idx(r_last_q, k);
            end
        end
    end

    // Grant selection: lock (if built in) overrides mode; SEL >= N never grants.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_ch    = '0;
        if (MODE) begin
            w_grant_valid = w_rr_valid;
            w_grant_ch    = w_rr_ch;
        end else if (int'(SEL) < N) begin
            w_grant_valid = IN_VALID[SEL];
            w_grant_ch    = SEL;
        end
`ifdef STREAM_MUX_LOCK_EN
        if (r_lock_q) begin
            w_grant_valid = IN_VALID[r_lock_ch_q];
            w_grant_ch    = r_lock_ch_q;
        end
`endif
    end

    assign w_xfer = w_load & w_grant_valid;

    // One-hot ready to the granted channel, suppressed during reset.
    always_comb begin
        w_ready             = '0;
        w_ready[w_grant_ch] = w_xfer & !RESET;
    end

    assign IN_READY = w_ready;

    // Next state of the output stage and arbitration pointer.
    always_comb begin
        w_out_data_d  = r_out_data_q;
        w_out_valid_d = r_out_valid_q;
        w_out_ch_d    = r_out_ch_q;
        w_last_d      = r_last_q;
`ifdef STREAM_MUX_LOCK_EN
        w_out_last_d  = r_out_last_q;
        w_lock_d      = r_lock_q;
        w_lock_ch_d   = r_lock_ch_q;
`endif
        if (w_load) begin
            w_out_valid_d = w_xfer;
            if (w_xfer) begin
                w_out_data_d = IN_DATA[int'(w_grant_ch)*WIDTH +: WIDTH];
                w_out_ch_d   = w_grant_ch;
                w_last_d     = w_grant_ch;
`ifdef STREAM_MUX_LOCK_EN
                w_out_last_d = IN_LAST[w_grant_ch];
                w_lock_d     = !IN_LAST[w_grant_ch];
                w_lock_ch_d  = w_grant_ch;
`endif
            end
        end
    end

    // State registers; pointer resets to N-1 so channel 0 wins first.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_data_q  <= '0;
            r_out_valid_q <= 1'b0;
            r_out_ch_q    <= '0;
            r_last_q      <= SELW'(N - 1);
`ifdef STREAM_MUX_LOCK_EN
            r_out_last_q  <= 1'b0;
            r_lock_q      <= 1'b0;
            r_lock_ch_q   <= '0;
`endif
        end else begin
            r_out_data_q  <= w_out_data_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_ch_q    <= w_out_ch_d;
            r_last_q      <= w_last_d;
`ifdef STREAM_MUX_LOCK_EN
            r_out_last_q  <= w_out_last_d;
            r_lock_q      <= w_lock_d;
            r_lock_ch_q   <= w_lock_ch_d;
`endif
        end
    end

    assign OUT_DATA  = r_out_data_q;
    assign OUT_VALID = r_out_valid_q;
    assign OUT_CH    = r_out_ch_q;
`ifdef STREAM_MUX_LOCK_EN
    assign OUT_LAST  = r_out_last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux_rr
//  Description : Scoreboard bench for stream_mux_rr (N=4 and N=3 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic        rst3;
    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [15:0] out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

`ifdef STREAM_MUX_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
    logic [2:0]  in_last3;
    logic        out_last3;
`endif

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(16), .N(4)) dut (
        .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
        .IN_READY(in_ready), .MODE(mode), .SEL(sel), .OUT_DATA(out_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CH(out_ch)
`ifdef STREAM_MUX_LOCK_EN
        , .IN_LAST(in_last), .OUT_LAST(out_last)
`endif
    );

    stream_mux_rr #(.WIDTH(16), .N(3)) dut3 (
        .CLK(clk), .RESET(rst3), .IN_DATA(in_data3), .IN_VALID(in_valid3),
        .IN_READY(in_ready3), .MODE(mode3), .SEL(sel3), .OUT_DATA(out_data3),
        .OUT_VALID(out_valid3), .OUT_READY(out_ready3), .OUT_CH(out_ch3)
`ifdef STREAM_MUX_LOCK_EN
        , .IN_LAST(in_last3), .OUT_LAST(out_last3)
`endif
    );

    // Scoreboard: every beat consumed from the N=4 instance must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got ch=%0d data=%h, required no beat", out_ch, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (out_ch !== e.ch || out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL scoreboard_beat: got ch=%0d data=%h, required ch=%0d data=%h",
                             out_ch, out_data, e.ch, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        mode = 1'b1; sel = 2'd0; out_ready = 1'b1; in_valid = 4'hF;
        in_data = {16'hA030, 16'hA020, 16'hA010, 16'hA000};
        mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1; in_valid3 = 3'b000; in_data3 = '0;
`ifdef STREAM_MUX_LOCK_EN
        in_last = 4'h0; in_last3 = 3'b000;
`endif
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0000", out_data); end
        n_checks++;
        if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d, required 0", out_ch); end
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready); end
        rst = 1'b0; rst3 = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_rr: got %b, required 0001", in_ready); end
        exp_q.push_back('{2'd0, 16'hA000});
        tick();
        in_valid = 4'h0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drain: got %b, required 0", out_valid); end
    endtask

    task automatic test_explicit();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        in_data = {16'hC003, 16'hBEEF, 16'hC001, 16'hC000};
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel2_ready: got %b, required 0100", in_ready); end
        exp_q.push_back('{2'd2, 16'hBEEF});
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL sel2_out: got v=%b data=%h ch=%0d, required v=1 data=beef ch=2", out_valid, out_data, out_ch);
        end
        in_valid = 4'b1011;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL sel2_invalid_ready: got %b, required 0000", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'hBEEF || out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL no_grant_hold: got v=%b data=%h ch=%0d, required v=0 data=beef ch=2", out_valid, out_data, out_ch);
        end
        sel = 2'd3; in_valid = 4'b1000;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL sel3_ready: got %b, required 1000", in_ready); end
        exp_q.push_back('{2'd3, 16'hC003});
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch;
        mode = 1'b1; in_valid = 4'hF;
        in_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        for (int k = 0; k < 6; k++) begin
            exp_ch = 2'(k % 4);
            #1;
            n_checks++;
            if (in_ready !== (4'b0001 << exp_ch)) begin
                n_fail++;
                $display("FAIL rr_seq_%0d: got ready %b, required ch %0d", k, in_ready, exp_ch);
            end
            exp_q.push_back('{exp_ch, 16'hD000 + 16'(exp_ch)});
            tick();
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_stall();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
        in_data = {16'h0, 16'h0, 16'h1234, 16'h0};
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_first_ready: got %b, required 0010", in_ready); end
        exp_q.push_back('{2'd1, 16'h1234});
        tick();
        out_ready = 1'b0;
        in_data = {16'h0, 16'h0, 16'h5678, 16'h0};
        for (int k = 0; k < 3; k++) begin
            mode = (k == 1);
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready_%0d: got %b, required 0000", k, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_ch !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b data=%h ch=%0d, required v=1 data=1234 ch=1", k, out_valid, out_data, out_ch);
            end
        end
        mode = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_release_ready: got %b, required 0010", in_ready); end
        exp_q.push_back('{2'd1, 16'h5678});
        tick();
        n_checks++;
        if (out_data !== 16'h5678) begin n_fail++; $display("FAIL stall_next_beat: got %h, required 5678", out_data); end
        in_valid = 4'h0;
        tick();
    endtask

`ifdef STREAM_MUX_LOCK_EN
    task automatic test_lock();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_last = 4'b0001;
        in_data = {16'hE003, 16'hE002, 16'hE001, 16'hE000};
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_setup_ready: got %b, required 0001", in_ready); end
        exp_q.push_back('{2'd0, 16'hE000});
        tick();
        mode = 1'b1; in_valid = 4'b0111; in_last = 4'b0000;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_beat1_ready: got %b, required 0010", in_ready); end
        exp_q.push_back('{2'd1, 16'hE001});
        tick();
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL lock_beat1_last: got %b, required 0", out_last); end
        in_valid = 4'b0101;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_gap_ready: got %b, required 0000", in_ready); end
        tick();
        in_valid = 4'b0111;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_beat2_ready: got %b, required 0010", in_ready); end
        exp_q.push_back('{2'd1, 16'hE001});
        tick();
        in_last = 4'b0010;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_beat3_ready: got %b, required 0010", in_ready); end
        exp_q.push_back('{2'd1, 16'hE001});
        tick();
        n_checks++;
        if (out_last !== 1'b1) begin n_fail++; $display("FAIL lock_beat3_last: got %b, required 1", out_last); end
        in_last = 4'b0000;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_release_ready: got %b, required 0100", in_ready); end
        exp_q.push_back('{2'd2, 16'hE002});
        tick();
        in_valid = 4'h0;
        tick();
    endtask
`endif

    task automatic test_sel_out_of_range();
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {16'h0C02, 16'h0C01, 16'h0C00};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL n3_sel3_ready_%0d: got %b, required 000", k, in_ready3); end
            tick();
            n_checks++;
            if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL n3_sel3_valid_%0d: got %b, required 0", k, out_valid3); end
        end
        sel3 = 2'd1;
        #1;
        n_checks++;
        if (in_ready3 !== 3'b010) begin n_fail++; $display("FAIL n3_sel1_ready: got %b, required 010", in_ready3); end
        tick();
        out_ready3 = 1'b0;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 16'h0C01) begin
            n_fail++;
            $display("FAIL n3_stall_hold: got v=%b data=%h, required v=1 data=0c01", out_valid3, out_data3);
        end
        rst3 = 1'b1;
        #1;
        n_checks++;
        if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL n3_reset_ready: got %b, required 000", in_ready3); end
        tick();
        n_checks++;
        if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL n3_reset_valid: got %b, required 0", out_valid3); end
        rst3 = 1'b0; mode3 = 1'b1; out_ready3 = 1'b1;
        #1;
        n_checks++;
        if (in_ready3 !== 3'b001) begin n_fail++; $display("FAIL n3_reset_pointer: got %b, required 001", in_ready3); end
        tick();
        n_checks++;
        if (out_ch3 !== 2'd0 || out_data3 !== 16'h0C00) begin
            n_fail++;
            $display("FAIL n3_reset_first_out: got ch=%0d data=%h, required ch=0 data=0c00", out_ch3, out_data3);
        end
        in_valid3 = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_round_robin();
        test_stall();
`ifdef STREAM_MUX_LOCK_EN
        test_lock();
`endif
        test_sel_out_of_range();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d beats pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
